// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Purpose:
//     Single-port word-addressed data memory that answers one load or store
//     request at a time after a fixed latency. Each request is captured in
//     IDLE. It then waits LATENCY-1 cycles in WAIT and performs the access.
//     The result is presented for exactly one cycle in RESP. Requests arriving
//     while WAIT or RESP is active are ignored. They are not queued.
//
// Parameters:
//     DEPTH_WORDS  storage depth in 32-bit words (power of two, 4..1024)
//     LATENCY      cycles from request capture to response (1..15)
//
// Ports:
//     clk_i    input   1   clock; all state changes on the rising edge
//     rst_i    input   1   asynchronous active-low reset; clears all storage
//     req_i    input   1   request valid, sampled in IDLE
//     we_i     input   1   1 = store word, 0 = load word
//     addr_i   input  32   byte address
//     wdata_i  input  32   store data
//     ack_o    output  1   one-cycle response pulse
//     rdata_o  output 32   load data; held until the next response
//     err_o    output  1   access rejected; held until the next response
//
// Configuration:
//     DMEM_ALIGN_CHECK_EN  when defined, an address whose low two bits are not
//                          zero is rejected. This check takes priority over the
//                          range check. When undefined, the low two bits are
//                          ignored.

module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        count;
    logic              cap_we;
    logic [31:0]       cap_addr;
    logic [31:0]       cap_wdata;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic              out_of_range;
    logic              misaligned;
    logic              reject;
    logic              access_now;
    logic              accept;

    // A request is only accepted in IDLE. The access itself happens on the
    // edge where WAIT sees the latency counter already at zero.
    assign accept     = (state == IDLE) && req_i;
    assign access_now = (state == WAIT) && (count == 4'd0);

    // The word index comes from the captured address, not the live inputs.
    // This lets the initiator change addr_i freely while the access is in
    // flight. Any address bit above the index field marks the access as
    // beyond the storage depth.
    assign word_idx     = cap_addr[IDX_W+1:2];
    assign out_of_range = |cap_addr[31:IDX_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned byte addresses are rejected outright.
    assign misaligned = |cap_addr[1:0];
`else
    // The low address bits carry no meaning for word accesses. They are folded
    // into an unused signal only so that they are consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cap_addr[1:0];
    assign misaligned       = 1'b0;
`endif

    assign reject = misaligned || out_of_range;

    // State register. Reset drops straight back to IDLE. This aborts any
    // access that is waiting or being reported.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and acknowledge logic. RESP always lasts exactly one cycle.
    // ack_o is decoded directly from the state register, so it drops at the
    // same moment as an asynchronous reset.
    always_comb begin
        state_next = state;
        ack_o      = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                ack_o      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture and latency counter. The counter is loaded with
    // LATENCY-1, so the access lands LATENCY edges after capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count     <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
        end else if (accept) begin
            count     <= 4'(LATENCY - 1);
            cap_we    <= we_i;
            cap_addr  <= addr_i;
            cap_wdata <= wdata_i;
        end else if ((state == WAIT) && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // Storage array. Every word is cleared by reset, so a store that was
    // aborted before its access edge leaves no trace. Rejected stores never
    // write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (access_now && cap_we && !reject) begin
            mem[word_idx] <= cap_wdata;
        end
    end

    // Response data and error flag. These are updated only on the access
    // edge, so they remain stable after ack_o falls until the next access.
    // Stores and rejected accesses return zero data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_o <= 32'd0;
            err_o   <= 1'b0;
        end else if (access_now) begin
            err_o <= reject;
            if (!reject && !cap_we) begin
                rdata_o <= mem[word_idx];
            end else begin
                rdata_o <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Purpose:
//     Scoreboard bench for data_mem_responder. Each issued request is
//     evaluated against a plain array model of the memory. The expected
//     response, together with the cycle on which it must appear, is pushed
//     into a queue. An independent monitor pops and compares whenever the DUT
//     acknowledges. The monitor also checks that outputs hold between
//     responses and that nothing is acknowledged early, late or twice.
//
// Ports: none (top-level bench). Honours DMEM_ALIGN_CHECK_EN in its model.

module tb_data_mem_responder;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          checks;
    int          failures;
    int          cyc;

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .ack_o  (ack_o),
        .rdata_o(rdata_o),
        .err_o  (err_o)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Single comparison point. Every check in the bench goes through here, so
    // the totals in the summary line come from these two counters.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, required 0x%08h",
                     name, cyc, actual, required);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge. cyc counts the
    // rising edges seen so far. A response to a request captured on edge c
    // must be visible right after edge c+LAT.
    initial begin
        exp_t        e;
        logic [31:0] last_rdata;
        logic        last_err;
        cyc        = 0;
        last_rdata = 32'd0;
        last_err   = 1'b0;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            if (!rst_i) begin
                checkOutput("reset_ack", 32'(ack_o), 32'd0);
                checkOutput("reset_err", 32'(err_o), 32'd0);
                checkOutput("reset_rdata", rdata_o, 32'd0);
                last_rdata = 32'd0;
                last_err   = 1'b0;
            end else if (ack_o) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(ack_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ack_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("resp_err", 32'(err_o), 32'(e.err));
                    checkOutput("resp_rdata", rdata_o, e.rdata);
                    last_rdata = e.rdata;
                    last_err   = e.err;
                end
            end else begin
                checkOutput("hold_rdata", rdata_o, last_rdata);
                checkOutput("hold_err", 32'(err_o), 32'(last_err));
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    checkOutput("missing_ack", 32'(ack_o), 32'd1);
                end
            end
        end
    end

    // Issues one request. It must be called at a falling edge while the DUT is
    // idle. The reference model applies the access immediately and queues the
    // expected response. While the access is in flight, every input is
    // scrambled, including req_i. The task returns at the first falling edge
    // from which a new request can be captured, so consecutive calls form a
    // continuously held request stream.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        exp_t e;
        logic reject;
        reject = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if (addr % 4 != 0) reject = 1'b1;
`endif
        e.cyc   = cyc + 1 + LAT;
        e.err   = reject;
        e.rdata = 32'd0;
        if (!reject) begin
            if (we) model_mem[addr / 4] = wdata;
            else    e.rdata = model_mem[addr / 4];
        end
        exp_q.push_back(e);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        for (int i = 1; i <= LAT + 2; i++) begin
            @(negedge clk_i);
            if (i <= LAT + 1) begin
                req_i   = 1'($urandom_range(0, 1));
                we_i    = 1'($urandom_range(0, 1));
                addr_i  = $urandom;
                wdata_i = $urandom;
            end else begin
                req_i = 1'b0;
            end
        end
    endtask

    // Starts a store to 0x8 and then pulls reset while the store is waiting.
    // The response must vanish at once. The model memory returns to all zero
    // because the store never reached its access edge.
    task automatic resetDuringWait();
        req_i   = 1'b1;
        we_i    = 1'b1;
        addr_i  = 32'h8;
        wdata_i = 32'h1234_5678;
        @(negedge clk_i);
        req_i = 1'b0;
        rst_i = 1'b0;
        #1;
        checkOutput("abort_ack", 32'(ack_o), 32'd0);
        checkOutput("abort_err", 32'(err_o), 32'd0);
        checkOutput("abort_rdata", rdata_o, 32'd0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        exp_q.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Main sequence: directed cases first, then randomized traffic, then a
    // bounded drain of the scoreboard before the summary.
    initial begin
        logic [31:0] a;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        rst_i   = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = 32'd0;
        wdata_i = 32'd0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;

        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h10, 32'd0);

        applyStimulus(1'b0, 32'h10, 32'd0);
        applyStimulus(1'b0, 32'h14, 32'd0);
        applyStimulus(1'b0, 32'h10, 32'd0);

        applyStimulus(1'b1, 32'h1FC, 32'hCAFE_F00D);
        applyStimulus(1'b1, 32'h200, 32'h1111_1111);
        applyStimulus(1'b0, 32'h1FC, 32'd0);
        applyStimulus(1'b0, 32'h200, 32'd0);

        applyStimulus(1'b1, 32'h12, 32'hA5A5_A5A5);
        applyStimulus(1'b0, 32'h10, 32'd0);

        resetDuringWait();
        applyStimulus(1'b0, 32'h8, 32'd0);

        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            a = 32'($urandom_range(0, 4 * DEPTH + 63));
            if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h8000_0000;
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (LAT + 4) @(negedge clk_i);
        while (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            checkOutput("drain_missing_ack", 32'd0, 32'd1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 128, meaning storage depth in 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request capture to response (legal 1..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  initiator request valid.
REQ-006 SHALL have port we_i  input  1  1 = store word, 0 = load word; sampled with req_i.
REQ-007 SHALL have port addr_i  input  32  byte address; sampled with req_i.
REQ-008 SHALL have port wdata_i  input  32  store data; sampled with req_i.
REQ-009 SHALL have port ack_o  output  1  one-cycle response pulse.
REQ-010 SHALL have port rdata_o  output  32  load data, valid while ack_o=1.
REQ-011 SHALL have port err_o  output  1  access rejected, valid while ack_o=1.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP; only IDLE accepts requests.
REQ-013 In IDLE with req_i=1 at edge t0: SHALL capture we_i, addr_i, wdata_i, load counter with LATENCY-1, go to WAIT.
REQ-014 In WAIT: counter != 0 -> decrement, stay; counter = 0 -> perform access at that edge, go to RESP.
REQ-015 ack_o SHALL be 1 only in RESP, i.e. exactly one cycle, beginning after edge t0+LATENCY.
REQ-016 RESP SHALL return to IDLE unconditionally on the next edge; req_i in WAIT/RESP ignored, no queuing.
REQ-017 req_i still 1 in IDLE after RESP SHALL be taken as a new request (minimum spacing LATENCY+2 cycles).
REQ-018 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-019 Address >= 4*DEPTH_WORDS: err_o=1 with ack_o, store suppressed, rdata_o=0.
REQ-020 Valid load: rdata_o = stored word, err_o=0; valid store: word written, rdata_o=0, err_o=0.
REQ-021 rdata_o and err_o SHALL hold their values after ack_o falls until the next RESP.
REQ-022 Inputs changing after capture SHALL not affect the in-flight access.

Reset
REQ-023 rst_i=0 SHALL force, asynchronously: state IDLE, counter 0, ack_o=0, err_o=0, rdata_o=0, all storage words 0.
REQ-024 Reset mid-operation (WAIT or RESP) SHALL abort the access; a store not yet performed SHALL leave memory zeroed.
REQ-025 First request SHALL be accepted at the first rising edge with rst_i=1 and req_i=1.

Configuration
REQ-026 Macro DMEM_ALIGN_CHECK_EN defined: addr[1:0] != 0 SHALL give err_o=1, store suppressed, rdata_o=0 (checked before range).
REQ-027 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored; access proceeds per REQ-018..020.

Verification
REQ-028 LATENCY=2: store addr 0x10, data 0xDEADBEEF at t0 -> ack_o=1 after edge t0+2 only, err_o=0; load 0x10 -> rdata_o=0xDEADBEEF.
REQ-029 req_i held 1 continuously, 3 loads -> acks spaced exactly LATENCY+2 cycles, no extra/missing ack.
REQ-030 DEPTH_WORDS=128: store 0x200 -> ack_o=1, err_o=1; load 0x1FC -> err_o=0, data unchanged by rejected store.
REQ-031 With DMEM_ALIGN_CHECK_EN: store 0x12 -> err_o=1, word 4 unchanged; without macro: same store writes word 4.
REQ-032 rst_i=0 asserted in WAIT of store 0x8 = 0x12345678 -> ack_o=0 immediately; after release load 0x8 -> rdata_o=0.
REQ-033 wdata_i/addr_i changed during WAIT -> stored value and address equal those sampled at t0.
